beta_seq_ctrl: RTL and testbench
================================

// Module: beta_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the unpipelined Beta datapath sharing one single-port memory for fetch and data.
//  Steps FETCH -> EXEC -> [MEM] -> WB per instruction and qualifies the decoder's strobes (werf, mwr, pcsel).
//  Accepts the external interrupt and bus-timeout faults, overriding pcsel/wasel/wdsel at WB.
//  Sits between the CU decoder, the memory port and the PC/IR/register-file enables.
// PARAMETERS
//  WAIT_MAX   255  max cycles mem_req may wait for mem_ack before a bus fault (8-bit wait counter)
//  CNT_W      32   width of the retired-instruction counter
// PORTS
//  clk          in   1      system clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  irq          in   1      level interrupt request
//  pc_super     in   1      PC[31]; 1 = supervisor mode, interrupts masked
//  cu_moe       in   1      decoder: instruction reads memory (LD/LDR)
//  cu_mwr       in   1      decoder: instruction writes memory (ST)
//  cu_werf      in   1      decoder: instruction writes register file
//  cu_pcsel     in   3      decoder PCSEL
//  cu_wasel     in   1      decoder WASEL
//  cu_wdsel     in   2      decoder WDSEL
//  mem_ack      in   1      memory completion pulse (1 cycle)
//  mem_req      out  1      memory request, held until mem_ack
//  mem_we       out  1      write enable for current request
//  addr_sel     out  1      0 = address from PC, 1 = address from ALU
//  ir_load      out  1      load IR with memory read data
//  pc_en        out  1      commit next PC
//  werf_out     out  1      qualified register-file write enable
//  pcsel_out    out  3      PCSEL to PC mux
//  wasel_out    out  1      WASEL to write-address mux
//  wdsel_out    out  2      WDSEL to write-data mux
//  bus_err      out  1      sticky: a bus timeout occurred
//  retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
//  Reset: state=FETCH, all outputs 0, wait_cnt=0, irq_pend=0, bus_err=0, retired=0; reset mid-transfer drops mem_req next cycle.
//  FETCH: mem_req=1, addr_sel=0, mem_we=0; on mem_ack: ir_load=1 same cycle, -> EXEC.
//  EXEC: single cycle, no strobes; -> MEM if cu_moe|cu_mwr else -> WB.
//  MEM: mem_req=1, addr_sel=1, mem_we=cu_mwr; on mem_ack -> WB.
//  WB (1 cycle): pc_en=1; normally werf_out=cu_werf, pcsel/wasel/wdsel = cu_*; -> FETCH; retired+=1.
//  Interrupt at WB when irq_pend & !pc_super: werf_out=1, pcsel_out=3'b100, wasel_out=1, wdsel_out=2'b00;
//   instruction still retires; irq_pend cleared.
//  irq_pend set on any cycle irq=1; cleared only when taken.
//  Handshake: req/we/addr_sel stable while waiting; mem_ack with mem_req=0 ignored; ack same cycle as req raise is valid.
//  mem_we only ever 1 in MEM; no register write or PC commit outside WB (werf_out, pc_en 0 otherwise).
//  wait_cnt: clears on entering FETCH/MEM, +1 per unacked cycle; at WAIT_MAX w/o ack: drop req, bus_err<=1,
//   -> WB with pcsel_out=3'b011 (ILLOP), wasel_out=1, wdsel_out=2'b00, werf_out=1 (fault beats irq; irq stays pending).
//  retired wraps modulo 2^CNT_W; faulted instructions do not increment.
//  pcsel_out/wasel_out/wdsel_out are 0 outside WB.
// TESTING
//  ADD-type (cu_moe=0,cu_mwr=0,cu_werf=1), ack after 1 wait -> FETCH 2, EXEC 1, WB 1: pc_en & werf_out only in WB, retired=1.
//  LD (cu_moe=1), acks after 0 and 3 waits -> MEM entered, addr_sel=1, mem_we=0 for 4 cycles, WB werf_out=1.
//  ST (cu_mwr=1,cu_werf=0) -> MEM with mem_we=1, WB werf_out=0, pc_en=1.
//  irq pulse 1 cycle during FETCH, pc_super=0 -> WB pcsel_out=100, wasel_out=1, wdsel_out=00; with pc_super=1 held pending.
//  No ack for WAIT_MAX cycles in MEM -> mem_req drops, bus_err=1, WB pcsel_out=011, retired unchanged.
//  reset asserted mid-MEM wait -> next cycle mem_req=0, state FETCH, retired=0, bus_err=0.

Source files
------------

// File: rtl/beta_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : beta_seq_ctrl
// Description : Multi-cycle FETCH/EXEC/MEM/WB sequencer for the Beta datapath
//               with one shared memory port, interrupt and bus-timeout traps.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_seq_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    input  logic             pc_super,
    input  logic             cu_moe,
    input  logic             cu_mwr,
    input  logic             cu_werf,
    input  logic [2:0]       cu_pcsel,
    input  logic             cu_wasel,
    input  logic [1:0]       cu_wdsel,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_en,
    output logic             werf_out,
    output logic [2:0]       pcsel_out,
    output logic             wasel_out,
    output logic [1:0]       wdsel_out,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [7:0] c_wait_last    = 8'(WAIT_MAX - 1);
    localparam logic [2:0] c_pcsel_illop  = 3'b011;
    localparam logic [2:0] c_pcsel_irq    = 3'b100;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             run_q, run_d;
    logic             irq_pend_q, irq_pend_d;
    logic             bus_err_q, bus_err_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            run_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            bus_err_q  <= 1'b0;
            fault_q    <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            run_q      <= run_d;
            irq_pend_q <= irq_pend_d;
            bus_err_q  <= bus_err_d;
            fault_q    <= fault_d;
            retired_q  <= retired_d;
        end
    end

    // run_q holds every strobe low for the first cycle after reset, so a
    // reset in the middle of a transfer always drops mem_req for a cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        run_d      = 1'b1;
        irq_pend_d = irq_pend_q | irq;
        bus_err_d  = bus_err_q;
        fault_d    = fault_q;
        retired_d  = retired_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        werf_out   = 1'b0;
        pcsel_out  = 3'b000;
        wasel_out  = 1'b0;
        wdsel_out  = 2'b00;

        if (run_q) begin
            case (state_q)
                S_FETCH, S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = (state_q == S_MEM);
                    mem_we   = (state_q == S_MEM) & cu_mwr;
                    if (mem_ack) begin
                        ir_load = (state_q == S_FETCH);
                        state_d = (state_q == S_FETCH) ? S_EXEC : S_WB;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        if (wait_cnt_q == c_wait_last) begin
                            bus_err_d = 1'b1;
                            fault_d   = 1'b1;
                            state_d   = S_WB;
                        end
                    end
                end
                S_EXEC: begin
                    if (cu_moe | cu_mwr) begin
                        wait_cnt_d = 8'd0;
                        state_d    = S_MEM;
                    end else begin
                        state_d    = S_WB;
                    end
                end
                S_WB: begin
                    pc_en = 1'b1;
                    // A bus fault takes precedence; a pending irq survives it.
                    if (fault_q) begin
                        werf_out  = 1'b1;
                        pcsel_out = c_pcsel_illop;
                        wasel_out = 1'b1;
                        wdsel_out = 2'b00;
                    end else if (irq_pend_q && !pc_super) begin
                        werf_out   = 1'b1;
                        pcsel_out  = c_pcsel_irq;
                        wasel_out  = 1'b1;
                        wdsel_out  = 2'b00;
                        irq_pend_d = irq;
                    end else begin
                        werf_out  = cu_werf;
                        pcsel_out = cu_pcsel;
                        wasel_out = cu_wasel;
                        wdsel_out = cu_wdsel;
                    end
                    if (!fault_q) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    fault_d    = 1'b0;
                    wait_cnt_d = 8'd0;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus_err = bus_err_q;
    assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_beta_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_beta_seq_ctrl
// Description : Scoreboard bench for beta_seq_ctrl using directed instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beta_seq_ctrl;

    localparam int WAIT_MAX = 255;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             irq;
    logic             pc_super;
    logic             cu_moe;
    logic             cu_mwr;
    logic             cu_werf;
    logic [2:0]       cu_pcsel;
    logic             cu_wasel;
    logic [1:0]       cu_wdsel;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_load;
    logic             pc_en;
    logic             werf_out;
    logic [2:0]       pcsel_out;
    logic             wasel_out;
    logic [1:0]       wdsel_out;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    beta_seq_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .pc_super  (pc_super),
        .cu_moe    (cu_moe),
        .cu_mwr    (cu_mwr),
        .cu_werf   (cu_werf),
        .cu_pcsel  (cu_pcsel),
        .cu_wasel  (cu_wasel),
        .cu_wdsel  (cu_wdsel),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .pc_en     (pc_en),
        .werf_out  (werf_out),
        .pcsel_out (pcsel_out),
        .wasel_out (wasel_out),
        .wdsel_out (wdsel_out),
        .bus_err   (bus_err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             werf;
        logic [2:0]       pcsel;
        logic             wasel;
        logic [1:0]       wdsel;
        logic [CNT_W-1:0] ret;
    } wb_exp_t;

    wb_exp_t          exp_q[$];
    wb_exp_t          mon_e;
    wb_exp_t          drv_e;
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_retired = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: every WB cycle must match the oldest expected record.
    always @(negedge clk) begin
        if (reset === 1'b0 && pc_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: got pc_en=1 expected no WB");
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_werf",    64'(werf_out),  64'(mon_e.werf));
                check("wb_pcsel",   64'(pcsel_out), 64'(mon_e.pcsel));
                check("wb_wasel",   64'(wasel_out), 64'(mon_e.wasel));
                check("wb_wdsel",   64'(wdsel_out), 64'(mon_e.wdsel));
                check("wb_retired", 64'(retired),   64'(mon_e.ret));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    // Answer one memory request after 'waits' unacked cycles.
    task automatic serve(input int waits, input logic exp_addr, input logic exp_we,
                         input logic is_fetch, input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_req_seen"}, 64'(mem_req), 64'd1);
        for (int i = 0; i < waits; i++) begin
            check({tag, "_wait_req"},  64'(mem_req),  64'd1);
            check({tag, "_wait_addr"}, 64'(addr_sel), 64'(exp_addr));
            check({tag, "_wait_we"},   64'(mem_we),   64'(exp_we));
            check({tag, "_wait_ir"},   64'(ir_load),  64'd0);
            @(posedge clk); #1;
            irq = 1'b0;
        end
        mem_ack = 1'b1;
        #1;
        check({tag, "_ack_req"},  64'(mem_req),  64'd1);
        check({tag, "_ack_addr"}, 64'(addr_sel), 64'(exp_addr));
        check({tag, "_ack_we"},   64'(mem_we),   64'(exp_we));
        check({tag, "_ack_ir"},   64'(ir_load),  64'(is_fetch));
        @(posedge clk); #1;
        mem_ack = 1'b0;
        irq     = 1'b0;
    endtask

    task automatic exec_checks(input string tag);
        check({tag, "_exec_pc_en"}, 64'(pc_en),     64'd0);
        check({tag, "_exec_werf"},  64'(werf_out),  64'd0);
        check({tag, "_exec_req"},   64'(mem_req),   64'd0);
        check({tag, "_exec_pcsel"}, 64'(pcsel_out), 64'd0);
    endtask

    task automatic do_instr(input string tag, input logic moe, input logic mwr, input logic werf,
                            input logic [2:0] pcsel, input logic wasel, input logic [1:0] wdsel,
                            input int fw, input int mw, input logic irq_pulse, input logic take_irq);
        wb_exp_t e;
        cu_moe   = moe;
        cu_mwr   = mwr;
        cu_werf  = werf;
        cu_pcsel = pcsel;
        cu_wasel = wasel;
        cu_wdsel = wdsel;
        if (irq_pulse) irq = 1'b1;
        e.werf  = take_irq ? 1'b1   : werf;
        e.pcsel = take_irq ? 3'b100 : pcsel;
        e.wasel = take_irq ? 1'b1   : wasel;
        e.wdsel = take_irq ? 2'b00  : wdsel;
        e.ret   = exp_retired;
        exp_q.push_back(e);
        exp_retired = exp_retired + 1;
        serve(fw, 1'b0, 1'b0, 1'b1, {tag, "_fetch"});
        exec_checks(tag);
        @(posedge clk); #1;
        if (moe | mwr) serve(mw, 1'b1, mwr, 1'b0, {tag, "_mem"});
        check({tag, "_wb_pc_en"}, 64'(pc_en),   64'd1);
        check({tag, "_wb_we"},    64'(mem_we),  64'd0);
        check({tag, "_wb_req"},   64'(mem_req), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int bad;
        reset = 1'b1; irq = 1'b0; pc_super = 1'b0; mem_ack = 1'b0;
        cu_moe = 1'b0; cu_mwr = 1'b0; cu_werf = 1'b0;
        cu_pcsel = 3'b000; cu_wasel = 1'b0; cu_wdsel = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",     64'(mem_req),  64'd0);
        check("rst_pc_en",   64'(pc_en),    64'd0);
        check("rst_werf",    64'(werf_out), 64'd0);
        check("rst_ir_load", 64'(ir_load),  64'd0);
        check("rst_bus_err", 64'(bus_err),  64'd0);
        check("rst_retired", 64'(retired),  64'd0);
        reset = 1'b0;

        do_instr("add",  1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'b01, 1, 0, 1'b0, 1'b0);
        check("add_retired", 64'(retired), 64'd1);
        do_instr("ld0",  1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 2'b10, 0, 0, 1'b0, 1'b0);
        do_instr("ld3",  1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 2'b10, 0, 3, 1'b0, 1'b0);
        do_instr("st",   1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 2, 0, 1'b0, 1'b0);
        do_instr("jmp",  1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
        do_instr("irq",  1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'b01, 1, 0, 1'b1, 1'b1);
        pc_super = 1'b1;
        do_instr("sup",  1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 2'b01, 1, 0, 1'b1, 1'b0);
        pc_super = 1'b0;
        do_instr("pend", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01, 0, 0, 1'b0, 1'b1);

        // Bus timeout in MEM with an interrupt already pending.
        cu_moe = 1'b1; cu_mwr = 1'b0; cu_werf = 1'b1;
        cu_pcsel = 3'b000; cu_wasel = 1'b0; cu_wdsel = 2'b10;
        irq = 1'b1;
        drv_e = '{werf: 1'b1, pcsel: 3'b011, wasel: 1'b1, wdsel: 2'b00, ret: exp_retired};
        exp_q.push_back(drv_e);
        serve(0, 1'b0, 1'b0, 1'b1, "flt_fetch");
        exec_checks("flt");
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (mem_req !== 1'b1 || addr_sel !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check("flt_req_held_cycles_bad", 64'(bad), 64'd0);
        check("flt_req_drop", 64'(mem_req), 64'd0);
        check("flt_bus_err",  64'(bus_err), 64'd1);
        check("flt_wb_pc_en", 64'(pc_en),   64'd1);
        @(posedge clk); #1;
        check("flt_retired",  64'(retired), 64'(exp_retired));
        do_instr("post", 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b01, 0, 0, 1'b0, 1'b1);
        check("post_bus_err_sticky", 64'(bus_err), 64'd1);

        // Reset in the middle of a MEM wait.
        cu_moe = 1'b0; cu_mwr = 1'b1; cu_werf = 1'b0;
        serve(0, 1'b0, 1'b0, 1'b1, "rstm_fetch");
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        check("rstm_in_mem_we", 64'(mem_we), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstm_req",     64'(mem_req), 64'd0);
        check("rstm_retired", 64'(retired), 64'd0);
        check("rstm_bus_err", 64'(bus_err), 64'd0);
        reset = 1'b0;
        exp_retired = '0;
        @(posedge clk); #1;
        check("rstm_fetch_req",  64'(mem_req),  64'd1);
        check("rstm_fetch_addr", 64'(addr_sel), 64'd0);
        check("rstm_fetch_we",   64'(mem_we),   64'd0);
        do_instr("add2", 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'b01, 0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        check("end_retired",     64'(retired),      64'(exp_retired));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
